// File: rtl/demux1_8_reg_pkg.sv
// Shared definitions for the registered 1-to-8 demultiplexer.
package demux1_8_reg_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SEQ    = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/demux1_8_reg_lane_ctrl.sv
// Lane controller: sequential-fill FSM, lane counter, handshake ready,
// target-lane selection and frame-complete pulse.
module demux1_8_reg_lane_ctrl
  import demux1_8_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             mode_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             wr_en_o,
  output logic [SEL_W-1:0] wr_lane_o,
  output logic [SEL_W-1:0] cur_lane_o,
  output logic             frame_done_o
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             mode_q;
  logic             frame_done_q, frame_done_d;

  // Handshake, routing and next-state logic.
  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    in_ready_o   = enable_i && !rst && (state_q != GAP);
    wr_en_o      = in_valid_i && in_ready_o;
    // Routing follows the mode seen in the previous cycle, so a word taken
    // in the cycle Mode flips still obeys the old mode's rule.
    wr_lane_o    = (mode_q == MODE_DIRECT) ? sel_i : cnt_q;
    cur_lane_o   = wr_lane_o;
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;

    if (mode_q == MODE_SEQ) begin
      case (state_q)
        IDLE, FILL: begin
          if (wr_en_o) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d      = GAP;
              frame_done_d = 1'b1;
            end else begin
              state_d = FILL;
            end
          end
        end
        GAP: begin
          state_d = FILL;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // A mode change restarts framing; an already-earned Frame_done still fires.
    if (mode_i != mode_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // State, counter and pulse registers; mode copy tracks the input even in reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    mode_q <= mode_i;
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done_o = frame_done_q;

endmodule

// File: rtl/demux1_8_reg.sv
// Registered 1-to-8 demultiplexer: eight held output lanes written via a
// valid/ready handshake, lane chosen by Sel or by a sequential fill counter.
module demux1_8_reg
  import demux1_8_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Enable,
  input  logic             Mode,
  input  logic [SEL_W-1:0] Sel,
  input  logic [WIDTH-1:0] In,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [WIDTH-1:0] O5,
  output logic [WIDTH-1:0] O6,
  output logic [WIDTH-1:0] O7,
  output logic [WIDTH-1:0] O8,
  output logic [LANES-1:0] Lane_valid,
  output logic             Frame_done,
  output logic [SEL_W-1:0] Cur_lane
);

  logic             wr_en;
  logic [SEL_W-1:0] wr_lane;
  logic [WIDTH-1:0] lanes_q [LANES];
  logic [LANES-1:0] lane_valid_q;

  demux1_8_reg_lane_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (Enable),
    .mode_i      (Mode),
    .sel_i       (Sel),
    .in_valid_i  (In_valid),
    .in_ready_o  (In_ready),
    .wr_en_o     (wr_en),
    .wr_lane_o   (wr_lane),
    .cur_lane_o  (Cur_lane),
    .frame_done_o(Frame_done)
  );

  // Lane registers and one-hot write pulse; untargeted lanes hold.
  // NOTE: the lane array is reset on purpose because its contents are visible outputs that must read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) lanes_q[i] <= '0;
      lane_valid_q <= '0;
    end else begin
      lane_valid_q <= '0;
      if (wr_en) begin
        lanes_q[wr_lane]      <= In;
        lane_valid_q[wr_lane] <= 1'b1;
      end
    end
  end

  assign O1         = lanes_q[0];
  assign O2         = lanes_q[1];
  assign O3         = lanes_q[2];
  assign O4         = lanes_q[3];
  assign O5         = lanes_q[4];
  assign O6         = lanes_q[5];
  assign O7         = lanes_q[6];
  assign O8         = lanes_q[7];
  assign Lane_valid = lane_valid_q;

endmodule

// File: doc/demux1_8_reg.md
Name: demux1_8_reg

Overview:
- Registered 1-to-8 demultiplexer: the distribution end of the 8-input selector path.
- Accepts an 8-bit word with a valid/ready handshake and writes it into one of eight held output lanes.
- Lane is chosen directly by Sel, or by an internal sequential lane counter that fills all eight lanes as a frame.
- Sits upstream of the 8:1 selector, feeding its I1..I8 inputs.

Parameters:
- WIDTH, 8, data width of In and of each output lane.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- Enable  input  1  block enable; when low, no word is accepted.
- Mode  input  1  0 = direct (lane = Sel), 1 = sequential (lane = internal counter).
- Sel  input  3  lane select in direct mode; ignored in sequential mode.
- In  input  WIDTH  data word.
- In_valid  input  1  In holds a word.
- In_ready  output  1  block can accept a word this cycle.
- O1..O8  output  WIDTH each  held lane registers (O1 = lane 0 ... O8 = lane 7).
- Lane_valid  output  8  one-cycle pulse; bit k set in the cycle lane k is updated.
- Frame_done  output  1  one-cycle pulse after lane 7 is written in sequential mode.
- Cur_lane  output  3  lane that the next accepted word will target.

Behaviour:
- Reset (rst = 1 at a rising edge):
  - O1..O8 = 0, Lane_valid = 0, Frame_done = 0.
  - Lane counter = 0, state = IDLE.
  - In_ready = 0 while rst is high.
  - Reset applied mid-frame discards partial frame progress.
- Accept rule: accept = In_valid && In_ready at a rising edge.
- In_ready is combinational: Enable && !rst && state != GAP.
- Latency: accepted word appears on the target lane output exactly 1 cycle after accept. The matching Lane_valid bit is high for that same single cycle.
- Lanes not targeted hold their value. Outputs are always driven, never high-Z; Enable low only freezes them.
- Direct mode (Mode = 0):
  - Target lane = Sel, sampled at the accept edge.
  - Back-to-back accepts every cycle are allowed; writing the same lane twice keeps the last word.
  - The lane counter is not touched. Frame_done never pulses.
- Sequential mode (Mode = 1) state machine:
  - IDLE: Cur_lane = 0. On accept: write lane 0, counter = 1, go to FILL.
  - FILL: Cur_lane = counter. On accept: write lane[counter], counter = counter + 1.
    - An accept at counter = 7 writes lane 7, wraps counter to 0 (3-bit wrap) and goes to GAP.
    - No accept: hold state.
  - GAP: one-cycle bubble. In_ready = 0, Frame_done = 1 (coincides with Lane_valid[7] = 1). Next state is FILL with counter 0.
  - Cur_lane is 0 while in GAP and for the following first cycle of FILL.
- Mode change:
  - Any change of Mode forces state = IDLE and counter = 0 on the next edge.
  - A word accepted in the cycle Mode changes is routed using the old Mode's rule.
  - A pending Frame_done is not suppressed.
- Enable low mid-frame: In_ready = 0; state and counter hold; the frame resumes when Enable returns.
- Simultaneous rst and accept: reset wins, no write, no pulses.
- Lane_valid and Frame_done are registered and are 0 in every cycle with no write.

Decomposition:
- Shared package:
  - LANES = 8, SEL_W = 3.
  - Mode encodings MODE_DIRECT = 0, MODE_SEQ = 1.
  - State enum IDLE/FILL/GAP (2-bit).
- Natural sub-module: lane_ctrl.
  - Contains the FSM, lane counter, In_ready, Cur_lane and Frame_done.
  - Outputs a 3-bit target lane plus a write strobe.
- The top holds the eight WIDTH-bit lane registers and the Lane_valid decode.

Test Plan:
- Reset: hold rst for 2 cycles with In_valid = 1, In = 8'hFF -> O1..O8 = 0, Lane_valid = 0, In_ready = 0; one cycle after rst drops with Enable = 1, In_ready = 1.
- Direct: Mode = 0, accept In = 8'hA5 with Sel = 3'b101 -> next cycle O6 = 8'hA5 and Lane_valid = 8'b0010_0000; other lanes remain 0; a second accept of 8'h3C on Sel = 5 gives O6 = 8'h3C.
- Sequential frame: Mode = 1, In_valid held high, In = 8'h10..8'h17 -> O1..O8 = 8'h10..8'h17 over 8 cycles; Frame_done pulses with Lane_valid[7]; In_ready = 0 for exactly that one GAP cycle; next word 8'h20 lands in O1.
- Enable stall: sequential mode, drop Enable after 3 words for 4 cycles -> In_ready = 0, Cur_lane stays 3, outputs hold; the next word lands in O4.
- Mode switch mid-frame: 5 words accepted in Mode = 1, then Mode = 0, then Mode = 1 -> Cur_lane = 0 and the next sequential word lands in O1; no Frame_done pulse occurs.
- Reset mid-frame: rst asserted after 6 sequential words -> all lanes = 0, Cur_lane = 0, no Frame_done.
